choice_table_ctrl: RTL and testbench
====================================

Name: choice_table_ctrl

Overview:
- Sequencer/arbiter for the tournament choice table: 2^IDX_W entries of CTR_W-bit saturating counters, held in an external synchronous RAM with one read port and one write port.
- Initialises every entry after reset, then shares the single read port between front-end lookups and queued training updates.
- Training updates are performed as read-modify-write.
- Sits between the fetch-side predictor logic and the resolve-side training logic.

Parameters:
- IDX_W, 12, table index width (global-history width)
- CTR_W, 3, counter width
- FIFO_DEPTH, 4, update queue entries (power of 2, ≥2)
- INIT_VAL, 3'b100, counter value written during init (weakly "global")

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- upd_valid  in  1  training request
- upd_ready  out  1  request accepted when upd_valid&&upd_ready
- upd_idx  in  IDX_W  entry to train
- upd_global_correct  in  1  global component predicted correctly
- upd_local_correct  in  1  local component predicted correctly
- lk_valid  in  1  lookup request
- lk_ready  out  1  lookup accepted when lk_valid&&lk_ready
- lk_idx  in  IDX_W  entry to read
- lk_resp_valid  out  1  lookup result valid
- lk_choice  out  1  1=use global, 0=use local
- tbl_ren  out  1  RAM read enable
- tbl_raddr  out  IDX_W  RAM read address
- tbl_rdata  in  CTR_W  RAM data, valid the cycle after tbl_ren; returns old data on same-cycle read/write collision
- tbl_we  out  1  RAM write enable
- tbl_waddr  out  IDX_W  RAM write address
- tbl_wdata  out  CTR_W  RAM write data
- init_busy  out  1  init sweep in progress

Behaviour:
- Reset values while reset is high:
  - state=INIT, sweep addr=0, FIFO empty, RMW stage and forward register invalid.
  - upd_ready=0, lk_ready=0, lk_resp_valid=0, tbl_ren=0, tbl_we=0, init_busy=1.
- FSM INIT:
  - One write per cycle: tbl_we=1, waddr=sweep addr, wdata=INIT_VAL, for addrs 0..2^IDX_W-1.
  - Exactly 2^IDX_W cycles, then RUN.
  - upd_ready=lk_ready=0; tbl_ren=0.
- FSM RUN: init_busy=0; no transition except on reset.
- Ready signals: lk_ready = upd_ready = RUN && (fifo_count < FIFO_DEPTH).
- Accepted update where global_correct==local_correct: consumed, not enqueued, no table effect.
- Accepted update otherwise: enqueue {idx, inc=global_correct}. An entry enqueued at cycle E is first issuable at E+1; no bypass.
- Read-port arbitration, RUN, per cycle, in priority order:
  - FIFO full → issue head update (lk_ready is already 0).
  - else lk_valid → issue lookup.
  - else FIFO non-empty → issue head update.
  - else idle.
- Update RMW:
  - Issue cycle N: tbl_ren=1, raddr=idx, pop FIFO, load stage-1 {idx, inc}.
  - Cycle N+1: v = fwd(tbl_rdata); tbl_we=1, waddr=idx, wdata = inc ? min(v+1, 2^CTR_W-1) : max(v-1, 0).
  - No wrap-around.
- Lookup: issue cycle N: tbl_ren=1, raddr=lk_idx. Cycle N+1: lk_resp_valid=1, lk_choice=fwd(tbl_rdata)[CTR_W-1]. Lookups are single-cycle, never stalled once accepted.
- Forwarding:
  - The write performed at cycle N is captured as {addr, data}, valid at N+1.
  - fwd(x) = captured data if the read returning at N+1 was issued at N to the same addr; else x.
  - Covers back-to-back updates to one index and a lookup colliding with a write.
- Throughput: one read issue per cycle; one write per cycle.
- Reset mid-operation: FIFO flushed, in-flight RMW and lookup responses dropped (no tbl_we, no lk_resp_valid the cycle after reset), INIT restarts at addr 0.

Decomposition:
- choice_pkg holds:
  - CHOICE_IDX_W, CHOICE_CTR_W, CHOICE_INIT_VAL.
  - typedef upd_entry_t {idx, inc}.
  - Function sat_step(val, inc).
- One sub-module: choice_upd_fifo (parameterised sync FIFO of upd_entry_t with count output).

Test Plan:
- Init: release reset → init_busy=1 for exactly 4096 cycles, tbl_we with waddr 0..4095, wdata=4; then lk_ready=1.
- Single train+lookup:
  - Update idx 5, global=1, local=0, accepted at E → tbl_raddr=5 at E+1; tbl_we, wdata=5 at E+2.
  - Lookup idx 5 accepted at E+2 → lk_resp_valid at E+3, lk_choice=1 (forwarded).
- Back-to-back decrements: two updates idx 7 (global=0, local=1) on consecutive cycles, table=4 → writes 3 then 2 on consecutive cycles.
- Saturation and drop:
  - Eight increments on idx 9 → final write 7, no wrap.
  - Update with global=local=1 → no tbl_we.
- Arbitration: lk_valid held high while 4 updates enqueued → FIFO reaches 4, lk_ready=0, head update issues, lk_ready returns 1 next cycle.
- Reset mid-run: reset asserted with FIFO holding 3 entries → no tbl_we and no lk_resp_valid after reset, sweep restarts at waddr 0.

Source files
------------

// File: rtl/choice_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : choice_pkg
//  Description : Shared types, constants and the saturating-counter step
//                used by the tournament choice-table controller.
//  Revision    : 1.0  initial release
// ============================================================================
package choice_pkg;

  localparam int CHOICE_IDX_W = 12;
  localparam int CHOICE_CTR_W = 3;
  localparam logic [CHOICE_CTR_W-1:0] CHOICE_INIT_VAL = 3'b100;

  // One queued training request: entry to train and direction.
  typedef struct packed {
    logic [CHOICE_IDX_W-1:0] idx;
    logic                    inc;
  } upd_entry_t;

  // Controller sequencing: sweep-initialise the table, then serve traffic.
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Saturating +/-1 on a choice counter; never wraps at either end.
  function automatic logic [CHOICE_CTR_W-1:0] sat_step(
    input logic [CHOICE_CTR_W-1:0] val,
    input logic                    inc
  );
    logic [CHOICE_CTR_W-1:0] res;
    res = val;
    if (inc) begin
      if (val != {CHOICE_CTR_W{1'b1}}) res = val + 1'b1;
    end else begin
      if (val != {CHOICE_CTR_W{1'b0}}) res = val - 1'b1;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/choice_upd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : choice_upd_fifo
//  Description : Synchronous FIFO of pending training updates with an
//                occupancy count. Show-ahead head output, no bypass.
//  Revision    : 1.0  initial release
// ============================================================================
module choice_upd_fifo
  import choice_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  upd_entry_t       i_data,
  input  logic             i_pop,
  output upd_entry_t       o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PTR_W = $clog2(DEPTH);

  upd_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Overflow/underflow requests are ignored so the count stays coherent.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Storage array: written on push only, contents need no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/choice_table_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : choice_table_ctrl
//  Description : Sequencer/arbiter for the tournament choice table. Sweeps
//                the external RAM to INIT_VAL after reset, then shares the
//                single read port between lookups and queued read-modify-
//                write training updates, forwarding the last write.
//  Revision    : 1.0  initial release
// ============================================================================
module choice_table_ctrl
  import choice_pkg::*;
#(
  parameter int               IDX_W      = CHOICE_IDX_W,
  parameter int               CTR_W      = CHOICE_CTR_W,
  parameter int               FIFO_DEPTH = 4,
  parameter logic [CTR_W-1:0] INIT_VAL   = CHOICE_INIT_VAL
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_global_correct,
  input  logic             upd_local_correct,
  input  logic             lk_valid,
  output logic             lk_ready,
  input  logic [IDX_W-1:0] lk_idx,
  output logic             lk_resp_valid,
  output logic             lk_choice,
  output logic             tbl_ren,
  output logic [IDX_W-1:0] tbl_raddr,
  input  logic [CTR_W-1:0] tbl_rdata,
  output logic             tbl_we,
  output logic [IDX_W-1:0] tbl_waddr,
  output logic [CTR_W-1:0] tbl_wdata,
  output logic             init_busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_sweep_addr;

  // Update pipeline stage 1 (read issued last cycle, write this cycle)
  logic             r_rmw_vld;
  logic [IDX_W-1:0] r_rmw_idx;
  logic             r_rmw_inc;
  // Lookup response pending (read issued last cycle)
  logic             r_lk_pend;
  // Address of the read issued last cycle
  logic [IDX_W-1:0] r_rd_addr;
  // Last cycle's write, used to patch a colliding read
  logic             r_fwd_vld;
  logic [IDX_W-1:0] r_fwd_addr;
  logic [CTR_W-1:0] r_fwd_data;

  upd_entry_t       w_head;
  upd_entry_t       w_enq_data;
  logic [CNT_W-1:0] w_count;
  logic             w_empty;
  logic             w_full;

  logic             w_run;
  logic             w_ready;
  logic             w_enq;
  logic             w_lk_fire;
  logic             w_issue_upd;
  logic [IDX_W-1:0] w_raddr;
  logic [CTR_W-1:0] w_rd_val;
  logic             w_we;
  logic [IDX_W-1:0] w_waddr;
  logic [CTR_W-1:0] w_wdata;

  // Reset gates every handshake/strobe so nothing leaks out while held.
  assign w_run   = (r_state == ST_RUN) && !reset;
  assign w_ready = w_run && (w_count < CNT_W'(FIFO_DEPTH));

  // Agreeing components carry no training information: accept and drop.
  assign w_enq      = upd_valid && w_ready && (upd_global_correct != upd_local_correct);
  assign w_enq_data = '{idx: upd_idx, inc: upd_global_correct};

  // Full queue takes the port (lookups are already blocked by ready);
  // otherwise lookups win and updates fill idle slots.
  assign w_lk_fire   = lk_valid && w_ready;
  assign w_issue_upd = w_run && !w_empty && (w_full || !lk_valid);
  assign w_raddr     = w_issue_upd ? w_head.idx : lk_idx;

  // RAM returns stale data when read and write hit the same address together.
  assign w_rd_val = (r_fwd_vld && (r_fwd_addr == r_rd_addr)) ? r_fwd_data : tbl_rdata;

  choice_upd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst     (reset),
    .i_push  (w_enq),
    .i_data  (w_enq_data),
    .i_pop   (w_issue_upd),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_INIT;
    else       r_state <= w_state_nxt;
  end

  // Next state and write-port control (init sweep or RMW write-back).
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_waddr     = r_sweep_addr;
    w_wdata     = INIT_VAL;
    if (!reset) begin
      case (r_state)
        ST_INIT: begin
          w_we = 1'b1;
          if (r_sweep_addr == {IDX_W{1'b1}}) w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (r_rmw_vld) begin
            w_we    = 1'b1;
            w_waddr = r_rmw_idx;
            w_wdata = sat_step(w_rd_val, r_rmw_inc);
          end
        end
        default: w_state_nxt = ST_INIT;
      endcase
    end
  end

  // Init sweep address: one entry per INIT cycle.
  always_ff @(posedge clock) begin
    if (reset)                   r_sweep_addr <= '0;
    else if (r_state == ST_INIT) r_sweep_addr <= r_sweep_addr + 1'b1;
  end

  // Read-return tracking: RMW stage, lookup response and write forwarding.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rmw_vld  <= 1'b0;
      r_rmw_idx  <= '0;
      r_rmw_inc  <= 1'b0;
      r_lk_pend  <= 1'b0;
      r_rd_addr  <= '0;
      r_fwd_vld  <= 1'b0;
      r_fwd_addr <= '0;
      r_fwd_data <= '0;
    end else begin
      r_rmw_vld  <= w_issue_upd;
      r_rmw_idx  <= w_head.idx;
      r_rmw_inc  <= w_head.inc;
      r_lk_pend  <= w_lk_fire;
      r_rd_addr  <= w_raddr;
      r_fwd_vld  <= w_we;
      r_fwd_addr <= w_waddr;
      r_fwd_data <= w_wdata;
    end
  end

  assign upd_ready     = w_ready;
  assign lk_ready      = w_ready;
  assign lk_resp_valid = r_lk_pend && !reset;
  assign lk_choice     = w_rd_val[CTR_W-1];
  assign tbl_ren       = w_issue_upd || w_lk_fire;
  assign tbl_raddr     = w_raddr;
  assign tbl_we        = w_we;
  assign tbl_waddr     = w_waddr;
  assign tbl_wdata     = w_wdata;
  assign init_busy     = (r_state == ST_INIT) || reset;

endmodule
`default_nettype wire

// File: tb/tb_choice_table_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_choice_table_ctrl
//  Description : Self-checking bench for choice_table_ctrl with a behavioural
//                synchronous RAM and a write/lookup scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_choice_table_ctrl;

  logic        clock;
  logic        reset;
  logic        upd_valid;
  logic        upd_ready;
  logic [11:0] upd_idx;
  logic        upd_global_correct;
  logic        upd_local_correct;
  logic        lk_valid;
  logic        lk_ready;
  logic [11:0] lk_idx;
  logic        lk_resp_valid;
  logic        lk_choice;
  logic        tbl_ren;
  logic [11:0] tbl_raddr;
  logic [2:0]  tbl_rdata;
  logic        tbl_we;
  logic [11:0] tbl_waddr;
  logic [2:0]  tbl_wdata;
  logic        init_busy;

  typedef struct packed {
    logic [11:0] addr;
    logic [2:0]  data;
  } wr_t;

  int          n_total = 0;
  int          n_bad   = 0;
  wr_t         exp_wr[$];
  logic        exp_lk[$];
  logic [2:0]  model [4096];
  logic [2:0]  ram   [4096];

  choice_table_ctrl u_dut (
    .clock              (clock),
    .reset              (reset),
    .upd_valid          (upd_valid),
    .upd_ready          (upd_ready),
    .upd_idx            (upd_idx),
    .upd_global_correct (upd_global_correct),
    .upd_local_correct  (upd_local_correct),
    .lk_valid           (lk_valid),
    .lk_ready           (lk_ready),
    .lk_idx             (lk_idx),
    .lk_resp_valid      (lk_resp_valid),
    .lk_choice          (lk_choice),
    .tbl_ren            (tbl_ren),
    .tbl_raddr          (tbl_raddr),
    .tbl_rdata          (tbl_rdata),
    .tbl_we             (tbl_we),
    .tbl_waddr          (tbl_waddr),
    .tbl_wdata          (tbl_wdata),
    .init_busy          (init_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous RAM: read returns old contents on a same-address write.
  always @(posedge clock) begin
    if (tbl_ren) tbl_rdata <= ram[tbl_raddr];
    if (tbl_we)  ram[tbl_waddr] <= tbl_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_step(input logic [2:0] v, input logic inc);
    if (inc) return (v == 3'd7) ? 3'd7 : v + 3'd1;
    else     return (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

  // Scoreboard side: every run-mode write and lookup response is matched.
  always @(negedge clock) begin
    wr_t e;
    if (reset) begin
      check("rst_outs", {tbl_we, lk_resp_valid, tbl_ren, upd_ready, lk_ready, init_busy}, 6'b000001);
    end else if (!init_busy) begin
      if (tbl_we) begin
        if (exp_wr.size() == 0) check("unexp_we", {tbl_waddr, 1'b0, tbl_wdata}, 32'hFFFF);
        else begin
          e = exp_wr.pop_front();
          check("wr_addr", tbl_waddr, e.addr);
          check("wr_data", tbl_wdata, e.data);
        end
      end
      if (lk_resp_valid) begin
        if (exp_lk.size() == 0) check("unexp_lk", 1, 0);
        else check("lk_choice", lk_choice, exp_lk.pop_front());
      end
    end
  end

  // Drive one cycle's inputs and, at the falling edge, record what will be accepted.
  task automatic cyc_begin(input bit lv, input int lidx, input bit uv, input int uidx,
                           input bit ug, input bit ul);
    lk_valid = lv; lk_idx = lidx[11:0];
    upd_valid = uv; upd_idx = uidx[11:0];
    upd_global_correct = ug; upd_local_correct = ul;
    @(negedge clock);
    if (lv && lk_ready) exp_lk.push_back(model[lidx][2]);
    if (uv && upd_ready && (ug != ul)) begin
      model[uidx] = ref_step(model[uidx], ug);
      exp_wr.push_back({uidx[11:0], model[uidx]});
    end
  endtask

  task automatic cyc_end();
    @(posedge clock); #1;
    lk_valid = 1'b0; upd_valid = 1'b0;
  endtask

  task automatic cyc(input bit lv, input int lidx, input bit uv, input int uidx,
                     input bit ug, input bit ul);
    cyc_begin(lv, lidx, uv, uidx, ug, ul);
    cyc_end();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic init_sweep_check(input string tag);
    int nbad;
    nbad = 0;
    for (int i = 0; i < 4096; i++) begin
      @(negedge clock);
      if (!(init_busy === 1'b1 && tbl_we === 1'b1 && tbl_waddr === i[11:0] &&
            tbl_wdata === 3'd4 && tbl_ren === 1'b0 && lk_ready === 1'b0 &&
            upd_ready === 1'b0 && lk_resp_valid === 1'b0)) nbad++;
    end
    check({tag, "_sweep"}, nbad, 0);
    @(negedge clock);
    check({tag, "_done"}, {init_busy, tbl_we, lk_ready, upd_ready}, 4'b0011);
    @(posedge clock); #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]   = 3'd1;
      model[i] = 3'd4;
    end
    reset = 1'b1; lk_valid = 1'b0; lk_idx = '0; upd_valid = 1'b0; upd_idx = '0;
    upd_global_correct = 1'b0; upd_local_correct = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Init sweep
    init_sweep_check("init");

    // Single train then colliding lookup on idx 5
    cyc(0, 0, 1, 5, 1, 0);
    cyc_begin(0, 0, 0, 0, 0, 0);
    check("t1_ren", {tbl_ren, tbl_raddr}, {1'b1, 12'd5});
    cyc_end();
    cyc_begin(1, 5, 0, 0, 0, 0);
    check("t1_we", {tbl_we, tbl_waddr, tbl_wdata}, {1'b1, 12'd5, 3'd5});
    cyc_end();
    cyc_begin(0, 0, 0, 0, 0, 0);
    check("t1_resp", {lk_resp_valid, lk_choice}, 2'b11);
    cyc_end();
    idle(2);

    // Back-to-back decrements on idx 7
    cyc(0, 0, 1, 7, 0, 1);
    cyc(0, 0, 1, 7, 0, 1);
    cyc_begin(0, 0, 0, 0, 0, 0);
    check("b2b_w1", {tbl_we, tbl_wdata}, {1'b1, 3'd3});
    cyc_end();
    cyc_begin(0, 0, 0, 0, 0, 0);
    check("b2b_w2", {tbl_we, tbl_wdata}, {1'b1, 3'd2});
    cyc_end();
    idle(2);

    // Saturation up on idx 9 and down on idx 7
    for (int k = 0; k < 8; k++) cyc(0, 0, 1, 9, 1, 0);
    idle(4);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 7, 0, 1);
    idle(4);
    cyc(1, 9, 0, 0, 0, 0);
    cyc(1, 7, 0, 0, 0, 0);
    idle(2);

    // Agreeing update is consumed without touching the table
    cyc_begin(0, 0, 1, 11, 1, 1);
    check("drop_rdy", upd_ready, 1);
    cyc_end();
    for (int k = 0; k < 3; k++) begin
      cyc_begin(0, 0, 0, 0, 0, 0);
      check("drop_nowe", tbl_we, 0);
      cyc_end();
    end

    // Arbitration: lookups starve updates until the queue fills
    for (int k = 0; k < 4; k++) cyc(1, 100, 1, 20 + k, 1, 0);
    cyc_begin(1, 100, 0, 0, 0, 0);
    check("arb_full", {lk_ready, upd_ready, tbl_ren, tbl_raddr}, {1'b0, 1'b0, 1'b1, 12'd20});
    cyc_end();
    cyc_begin(1, 100, 0, 0, 0, 0);
    check("arb_rdy", {lk_ready, tbl_ren, tbl_raddr}, {1'b1, 1'b1, 12'd100});
    cyc_end();
    idle(8);

    // Reset with three updates queued
    for (int k = 0; k < 3; k++) cyc(1, 100, 1, 30 + k, 0, 1);
    reset = 1'b1; lk_valid = 1'b0;
    exp_wr.delete(); exp_lk.delete();
    for (int i = 0; i < 4096; i++) model[i] = 3'd4;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    init_sweep_check("reinit");
    cyc(1, 30, 0, 0, 0, 0);
    idle(6);

    check("wr_q_empty", exp_wr.size(), 0);
    check("lk_q_empty", exp_lk.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
